// File: rtl/bit_serial_add_sub_controller.sv
// -----------------------------------------------------------------------------
// bit_serial_add_sub_controller
//
// Purpose:
//   WIDTH-bit two's-complement add/subtract computed serially, LSB first. One
//   one_bit_full_adder_subtractor cell is reused over WIDTH clock cycles. A
//   carry flop links consecutive bits. The operands and the result move through
//   shift registers. The surrounding datapath talks to it through a
//   start/busy/done handshake.
//
// Ports:
//   clk      in   1      rising-edge clock
//   rstn     in   1      asynchronous active-low reset
//   start    in   1      request pulse, sampled only in IDLE
//   a        in   WIDTH  operand A, captured on accepted start
//   b        in   WIDTH  operand B, captured on accepted start
//   opcode   in   1      0 = A+B, 1 = A-B, captured on accepted start
//   busy     out  1      high while the serial operation runs
//   done     out  1      single-cycle pulse, result fields valid
//   result   out  WIDTH  sum/difference modulo 2^WIDTH (held until next done)
//   cout     out  1      carry out of MSB (subtract: 1 = no borrow)
//   overflow out  1      signed overflow (carry into MSB ^ carry out of MSB)
// -----------------------------------------------------------------------------

module one_bit_full_adder_subtractor (
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic opcode,
  output logic sum,
  output logic cout
);
  // Inverting B for subtract gives one's complement. The seeded carry-in of 1
  // supplies the +1 that makes it two's complement.
  logic b_eff;

  assign b_eff = b ^ opcode;
  assign sum   = a ^ b_eff ^ cin;
  assign cout  = (a & b_eff) | (cin & (a ^ b_eff));
endmodule

module bit_serial_add_sub_controller #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             opcode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  logic [WIDTH-1:0]   res_sr_q, res_sr_d;
  logic               op_q, op_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               cout_q, cout_d;
  logic               overflow_q, overflow_d;

  logic               cell_sum;
  logic               cell_cout;

  one_bit_full_adder_subtractor u_cell (
    .a      (a_sr_q[0]),
    .b      (b_sr_q[0]),
    .cin    (carry_q),
    .opcode (op_q),
    .sum    (cell_sum),
    .cout   (cell_cout)
  );

  always_comb begin
    state_d    = state_q;
    a_sr_d     = a_sr_q;
    b_sr_d     = b_sr_q;
    res_sr_d   = res_sr_q;
    op_d       = op_q;
    carry_d    = carry_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = done_q;
    result_d   = result_q;
    cout_d     = cout_q;
    overflow_d = overflow_q;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        done_d = 1'b0;
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          op_d    = opcode;
          // Seeding the carry with the opcode completes two's complement.
          carry_d = opcode;
          cnt_d   = '0;
          state_d = S_RUN;
          busy_d  = 1'b1;
        end
      end

      S_RUN: begin
        // Each sum bit enters at the MSB. After WIDTH shifts, bit 0 is at the LSB.
        res_sr_d = {cell_sum, res_sr_q[WIDTH-1:1]};
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        carry_d  = cell_cout;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          // On the MSB cycle, carry_q still holds the carry into the MSB.
          result_d   = {cell_sum, res_sr_q[WIDTH-1:1]};
          cout_d     = cell_cout;
          overflow_d = carry_q ^ cell_cout;
          state_d    = S_DONE;
          busy_d     = 1'b0;
          done_d     = 1'b1;
        end
      end

      S_DONE: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        done_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      a_sr_q     <= '0;
      b_sr_q     <= '0;
      res_sr_q   <= '0;
      op_q       <= 1'b0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_sr_q     <= a_sr_d;
      b_sr_q     <= b_sr_d;
      res_sr_q   <= res_sr_d;
      op_q       <= op_d;
      carry_q    <= carry_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
      cout_q     <= cout_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign cout     = cout_q;
  assign overflow = overflow_q;

endmodule
